// File: rtl/data_mem_mmio_if.sv
// CPU data-port bundle between the memory stage and the data memory subsystem.
// Requests flow master->slave; load data returns combinationally in the same cycle.
interface data_mem_mmio_if;
   logic [31:0] data_addr;
   logic [31:0] mem_write_data;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [31:0] mem_read_data;

   modport master (
      output data_addr, mem_write_data, mem_read_en, mem_write_en,
      input  mem_read_data
   );

   modport slave (
      input  data_addr, mem_write_data, mem_read_en, mem_write_en,
      output mem_read_data
   );
endinterface

// File: rtl/data_mem_mmio.sv
// Data RAM plus MMIO window (console TX FIFO, compare timer) behind the CPU data port.
// Loads are combinational from current state; stores and side effects land at the clock edge.
module data_mem_mmio #(
   parameter int          RAM_WORDS  = 1024,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   data_mem_mmio_if.slave         bus,
   output logic [7:0]             tx_data_o,
   output logic                   tx_valid_o,
   input  logic                   tx_ready_i,
   output logic                   timer_irq_o,
   output logic                   bus_error_o
);
   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   ram_q [RAM_WORDS];
   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   tcount_q, tcount_d;
   logic [31:0]   tcmp_q;
   logic          ten_q, tien_q, tpend_q, tpend_d;
   logic          berr_q;

   logic [31:0]   wd;
   logic          re, we;
   logic [31:0]   mmio_off;
   logic          aligned, ram_hit, mmio_hit, illegal;
   logic          sel_tx, sel_status, sel_count, sel_cmp, sel_ctrl;
   logic [AW-1:0] ram_idx;
   logic          full, empty, pop, push_req, push, ovf_set, match;
   logic [31:0]   status;

   assign wd       = bus.mem_write_data;
   assign re       = bus.mem_read_en;
   assign we       = bus.mem_write_en;
   assign mmio_off = bus.data_addr - MMIO_BASE;
   assign aligned  = (bus.data_addr[1:0] == 2'b00);
   assign ram_hit  = aligned && (bus.data_addr < 32'(RAM_WORDS * 4));
   assign mmio_hit = aligned && (bus.data_addr >= MMIO_BASE) && (mmio_off <= 32'h10);
   assign illegal  = (re || we) && !(ram_hit || mmio_hit);
   assign ram_idx  = bus.data_addr[AW+1:2];

   assign sel_tx     = mmio_hit && (mmio_off[4:2] == 3'd0);
   assign sel_status = mmio_hit && (mmio_off[4:2] == 3'd1);
   assign sel_count  = mmio_hit && (mmio_off[4:2] == 3'd2);
   assign sel_cmp    = mmio_hit && (mmio_off[4:2] == 3'd3);
   assign sel_ctrl   = mmio_hit && (mmio_off[4:2] == 3'd4);

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign full     = (cnt_q == CW'(FIFO_DEPTH));
   assign empty    = (cnt_q == '0);
   assign pop      = !empty && tx_ready_i;
   assign push_req = we && sel_tx;
   assign push     = push_req && (!full || pop);
   assign ovf_set  = push_req && full && !pop;
   assign match    = ten_q && (tcount_q == tcmp_q);

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;

      ovf_d = ovf_q;
      if (we && sel_status && wd[2]) ovf_d = 1'b0;
      if (ovf_set)                   ovf_d = 1'b1;

      tcount_d = tcount_q;
      if (we && sel_count) tcount_d = wd;
      else if (ten_q)      tcount_d = tcount_q + 32'd1;

      tpend_d = tpend_q;
      if (we && sel_ctrl && wd[2]) tpend_d = 1'b0;
      if (match)                   tpend_d = 1'b1;
   end

   always_comb begin
      status       = '0;
      status[0]    = empty;
      status[1]    = full;
      status[2]    = ovf_q;
      status[11:8] = 4'(cnt_q);
   end

   always_comb begin
      bus.mem_read_data = '0;
      if (re && !illegal) begin
         if (ram_hit) bus.mem_read_data = ram_q[ram_idx];
         else if (sel_status) bus.mem_read_data = status;
         else if (sel_count)  bus.mem_read_data = tcount_q;
         else if (sel_cmp)    bus.mem_read_data = tcmp_q;
         else if (sel_ctrl)   bus.mem_read_data = {29'd0, tpend_q, tien_q, ten_q};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RAM_WORDS; i++) ram_q[i] <= '0;
      end else if (we && ram_hit) begin
         ram_q[ram_idx] <= wd;
      end
   end

   // Storage is not reset; only the pointers/count define what is visible.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wptr_q] <= wd[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         tcount_q <= '0;
         tcmp_q   <= '0;
         ten_q    <= 1'b0;
         tien_q   <= 1'b0;
         tpend_q  <= 1'b0;
         berr_q   <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         tcount_q <= tcount_d;
         tpend_q  <= tpend_d;
         if (we && sel_cmp) tcmp_q <= wd;
         if (we && sel_ctrl) begin
            ten_q  <= wd[0];
            tien_q <= wd[1];
         end
         berr_q <= illegal;
      end
   end

   assign tx_data_o   = fifo_q[rptr_q];
   assign tx_valid_o  = !empty;
   assign timer_irq_o = tpend_q & tien_q;
   assign bus_error_o = berr_q;
endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
- Data-side memory subsystem that sits directly downstream of the pipelined CPU's memory stage.
- Consumes the CPU data port (`data_addr`, `mem_write_data`, `mem_read_en`, `mem_write_en`) and returns `mem_read_data` combinationally within the same cycle, so the memory/writeback register can sample it.
- Contains a word-addressed data RAM plus a small MMIO window: a console TX FIFO with a valid/ready drain port, and a 32-bit compare timer with an interrupt output.

Parameters:
- `RAM_WORDS`, 1024, number of 32-bit RAM words; power of two.
- `MMIO_BASE`, 32'hFFFF_0000, base byte address of the MMIO window.
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `data_addr`  in  32  byte address from memory stage
- `mem_write_data`  in  32  store data
- `mem_read_en`  in  1  load strobe
- `mem_write_en`  in  1  store strobe
- `mem_read_data`  out  32  load data, combinational
- `tx_data`  out  8  FIFO head byte
- `tx_valid`  out  1  FIFO non-empty
- `tx_ready`  in  1  consumer accepts head this cycle
- `timer_irq`  out  1  timer interrupt, level
- `bus_error`  out  1  one-cycle pulse on an illegal access

Behaviour:
- Clocking/reset: one clock, `clk`; reset is synchronous and active-high (`rst`).
- On reset:
  - RAM is cleared to 0.
  - FIFO is emptied, overflow flag cleared.
  - TIMER_COUNT, TIMER_CMP and TIMER_CTRL are set to 0.
  - `tx_valid`=0, `timer_irq`=0, `bus_error`=0.
  - `tx_data` is undefined while `tx_valid`=0.
- Reset mid-operation: state is discarded as above; there is no partial completion.
- Address decode:
  - Misaligned access (`data_addr[1:0]`≠0) is illegal.
  - RAM hit when `data_addr` < RAM_WORDS*4; index is `data_addr[log2(RAM_WORDS)+1:2]`.
  - MMIO hit when `data_addr` is MMIO_BASE+{0x00,0x04,0x08,0x0C,0x10}.
  - Any other address is illegal.
- Reads:
  - `mem_read_data` is combinational from current state when `mem_read_en`=1.
  - It is 0 when `mem_read_en`=0 or the access is illegal.
  - Write-only and reserved register bits read as 0.
- Writes: take effect at the rising edge while `mem_write_en`=1.
- Both strobes high: the read returns the pre-write value; the write proceeds.
- Illegal access with either strobe high:
  - Write is ignored; read returns 0.
  - `bus_error`=1 for exactly the following cycle.
- MMIO 0x00 TX_DATA (W): pushes `mem_write_data[7:0]`.
  - If FIFO is full and no pop occurs this cycle, the byte is dropped and overflow is set (sticky).
  - Full FIFO with a pop in the same cycle: the push is accepted and overflow is not set.
- MMIO 0x04 TX_STATUS:
  - Bit0 empty, bit1 full, bit2 overflow.
  - Bits[11:8] entry count, 0..FIFO_DEPTH.
  - Writing 1 to bit2 clears overflow; a new overflow in the same cycle wins.
- FIFO:
  - `tx_valid` = count≠0; `tx_data` = head.
  - Pop when `tx_valid` & `tx_ready`.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push into an empty FIFO shows `tx_valid`=1 the next cycle (no fall-through).
  - Simultaneous push and pop leaves the count unchanged.
- MMIO 0x08 TIMER_COUNT (R/W):
  - Increments by 1 each cycle while CTRL.en=1, wrapping 0xFFFFFFFF→0.
  - A CPU write loads the value and takes precedence over the increment.
- MMIO 0x0C TIMER_CMP (R/W).
- MMIO 0x10 TIMER_CTRL:
  - Bit0 en (R/W), bit1 irq_en (R/W), bit2 pending (read; write 1 clears).
  - Match = en & (COUNT==CMP), using the pre-edge COUNT; pending is set at that edge.
  - Set wins over a same-cycle write-1-clear.
- `timer_irq` = pending & irq_en, registered state only (no combinational path from the bus).

Test Plan:
- Write 0xDEADBEEF to 0x0000_0010, read 0x0000_0010 next cycle → `mem_read_data`=0xDEADBEEF in the same cycle as `mem_read_en`; after `rst`, the read returns 0.
- Read 0x0000_0012 (misaligned) and 0x0001_0000 (out of range, RAM_WORDS=1024) → data 0 and a one-cycle `bus_error` pulse after each; RAM is unchanged.
- Hold `tx_ready`=0 and push 9 bytes 0x41..0x49 → STATUS count=8, full=1, overflow=1. Then `tx_ready`=1 → bytes 0x41..0x48 drain in order, one per cycle. Write 0x4 to STATUS → overflow=0.
- FIFO full with `tx_ready`=1 and a push of 0x5A in the same cycle → count stays 8, no overflow, 0x5A is the last byte out.
- Program CMP=5, COUNT=0, CTRL=0x3 → pending and `timer_irq` set the cycle after COUNT reads 5. Write CTRL=0x7 → `irq` clears. COUNT=0xFFFFFFFF wraps to 0.
- Assert `rst` with FIFO holding 3 bytes and the timer running → next cycle `tx_valid`=0, COUNT=0, `timer_irq`=0.
